mtm_alu_ctrl: RTL and testbench

//   Frame controller for the serial ALU. Accepts decoded bytes from the UART deserializer and

---
 rtl/mtm_alu_pkg.sv | 51 +++++
 rtl/mtm_alu_ctrl_txseq.sv | 52 +++++
 rtl/mtm_alu_ctrl.sv | 149 ++++++++++++++
 tb/tb_mtm_alu_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mtm_alu_pkg.sv
// Shared definitions for the serial ALU frame controller: opcodes, FSM states,
// error response bytes and the frame/response CRC functions.
package mtm_alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;

  // Error bytes are {1'b1, flags6, even parity}.
  localparam logic [7:0] ERR_DATA = 8'hC9;
  localparam logic [7:0] ERR_CRC  = 8'hA5;
  localparam logic [7:0] ERR_OP   = 8'h93;

  typedef enum logic [2:0] {
    S_COLLECT,
    S_CHECK,
    S_RUN,
    S_TX_RES,
    S_TX_ERR
  } state_e;

  function automatic logic op_is_valid(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

  // x^4+x+1, init 0, MSB first over {A, B, 1'b1, OP}.
  function automatic logic [3:0] crc4_d68(input logic [67:0] d);
    logic [3:0] c;
    logic       fb;
    c = '0;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ d[i];
      c  = {c[2], c[1], c[0] ^ fb, fb};
    end
    return c;
  endfunction

  // x^3+x+1, init 0, MSB first over {C, 1'b0, flags}.
  function automatic logic [2:0] crc3_d37(input logic [36:0] d);
    logic [2:0] c;
    logic       fb;
    c = '0;
    for (int i = 36; i >= 0; i--) begin
      fb = c[2] ^ d[i];
      c  = {c[1], c[0] ^ fb, fb};
    end
    return c;
  endfunction

endpackage

// File: rtl/mtm_alu_ctrl_txseq.sv
// Response sequencer: emits either five result bytes (C then CTL with CRC3)
// or a single error CTL byte, holding each byte until the serializer accepts it.
module mtm_alu_ctrl_txseq
  import mtm_alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        mode_err,
  input  logic [31:0] res_c,
  input  logic [3:0]  res_flags,
  input  logic [7:0]  err_byte,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_is_ctl,
  output logic        done
);

  logic [39:0] shreg_q;
  logic [2:0]  left_q;
  logic        accept;

  assign accept = tx_valid & tx_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
      left_q  <= '0;
    end else if (load) begin
      if (mode_err) begin
        shreg_q <= {err_byte, 32'h0};
        left_q  <= 3'd1;
      end else begin
        shreg_q <= {res_c, 1'b0, res_flags, crc3_d37({res_c, 1'b0, res_flags})};
        left_q  <= 3'd5;
      end
    end else if (accept) begin
      shreg_q <= {shreg_q[31:0], 8'h00};
      left_q  <= left_q - 3'd1;
    end
  end

  // The final byte of either response is always the CTL byte.
  assign tx_valid  = (left_q != 3'd0);
  assign tx_data   = shreg_q[39:32];
  assign tx_is_ctl = (left_q == 3'd1);
  assign done      = accept && (left_q == 3'd1);

endmodule

// File: rtl/mtm_alu_ctrl.sv
// Frame controller for the serial ALU: collects 8 DATA + 1 CTL byte, validates
// length/CRC4/opcode, runs the core and sequences the response. Optional macro: ALU_CTRL_TIMEOUT_EN.
module mtm_alu_ctrl
  import mtm_alu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        rx_is_ctl,
  output logic        rx_ready,
  output logic        alu_start,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic        alu_done,
  input  logic [31:0] alu_result,
  input  logic [3:0]  alu_flags,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_is_ctl,
  input  logic        tx_ready,
  output logic        busy
);

  state_e      state_q, state_d;
  logic [63:0] data_q;
  logic [3:0]  count_q;
  logic [2:0]  op_q;
  logic [3:0]  crc_q;
  logic        len_ok_q;
  logic        run_issued_q;

  logic        rx_take;
  logic        crc_ok;
  logic        frame_ok;
  logic [7:0]  err_byte;
  logic        seq_load;
  logic        seq_mode_err;
  logic        seq_done;
  logic        timeout;

  assign rx_take  = rx_valid && (state_q == S_COLLECT);
  assign crc_ok   = (crc4_d68({data_q, 1'b1, op_q}) == crc_q);
  assign frame_ok = len_ok_q && crc_ok && op_is_valid(op_q);
  assign err_byte = !len_ok_q ? ERR_DATA : (!crc_ok ? ERR_CRC : ERR_OP);

`ifdef ALU_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_q;

  // Fires on the TIMEOUT_CYCLES-th consecutive idle cycle of a partial frame.
  assign timeout = (state_q == S_COLLECT) && (count_q != 4'd0) && !rx_valid
                   && (idle_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_q <= '0;
    end else if ((state_q != S_COLLECT) || (count_q == 4'd0) || rx_valid || timeout) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_q + TW'(1);
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_COLLECT;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q       <= '0;
      count_q      <= '0;
      op_q         <= '0;
      crc_q        <= '0;
      len_ok_q     <= 1'b0;
      run_issued_q <= 1'b0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_op       <= '0;
    end else begin
      run_issued_q <= (state_q == S_RUN);
      if (timeout) begin
        data_q  <= '0;
        count_q <= '0;
      end else if (rx_take && !rx_is_ctl) begin
        data_q <= {data_q[55:0], rx_data};
        if (count_q != 4'd9) count_q <= count_q + 4'd1;
      end else if (rx_take && rx_is_ctl) begin
        op_q     <= rx_data[6:4];
        crc_q    <= rx_data[3:0];
        len_ok_q <= (count_q == 4'd8);
        count_q  <= '0;
      end
      // Operands are held from one start until the next.
      if ((state_q == S_CHECK) && frame_ok) begin
        alu_a  <= data_q[63:32];
        alu_b  <= data_q[31:0];
        alu_op <= op_q;
      end
    end
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_COLLECT: if (rx_take && rx_is_ctl) state_d = S_CHECK;
      S_CHECK:   state_d = frame_ok ? S_RUN : S_TX_ERR;
      S_RUN:     if (alu_done) state_d = S_TX_RES;
      S_TX_RES,
      S_TX_ERR:  if (seq_done) state_d = S_COLLECT;
      default:   state_d = S_COLLECT;
    endcase
  end

  always_comb begin
    rx_ready     = (state_q == S_COLLECT);
    busy         = (state_q != S_COLLECT);
    alu_start    = (state_q == S_RUN) && !run_issued_q;
    seq_load     = ((state_q == S_RUN) && alu_done) || ((state_q == S_CHECK) && !frame_ok);
    seq_mode_err = (state_q == S_CHECK);
  end

  mtm_alu_ctrl_txseq u_txseq (
    .clk       (clk),
    .rst       (rst),
    .load      (seq_load),
    .mode_err  (seq_mode_err),
    .res_c     (alu_result),
    .res_flags (alu_flags),
    .err_byte  (err_byte),
    .tx_ready  (tx_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_is_ctl (tx_is_ctl),
    .done      (seq_done)
  );

endmodule

// File: tb/tb_mtm_alu_ctrl.sv
// Directed, table-driven bench for mtm_alu_ctrl with hand-written sequences for
// tx back-pressure, reset during RUN, dropped bytes and the partial-frame timeout.
`timescale 1ns/1ps
module tb_mtm_alu_ctrl;

  localparam int TIMEOUT_CYCLES = 10000;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_is_ctl;
  logic        rx_ready;
  logic        alu_start;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic        alu_done;
  logic [31:0] alu_result;
  logic [3:0]  alu_flags;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_is_ctl;
  logic        tx_ready;
  logic        busy;

  mtm_alu_ctrl #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk(clk), .rst(rst),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_is_ctl(rx_is_ctl), .rx_ready(rx_ready),
    .alu_start(alu_start), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_done(alu_done), .alu_result(alu_result), .alu_flags(alu_flags),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_is_ctl(tx_is_ctl), .tx_ready(tx_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int start_cnt = 0;

  always @(posedge clk) if (alu_start === 1'b1) start_cnt++;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          n;      // DATA bytes sent (9 appends an extra 0x00)
    logic [2:0]  op;
    bit          raw;    // send ctl verbatim instead of {0,op,crc4}
    logic [7:0]  ctl;
    logic [31:0] res;
    logic [3:0]  flg;
    logic [7:0]  err;    // 0 = expect a result response
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference CRCs by polynomial long division of message * x^n.
  function automatic logic [3:0] m_crc4(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op);
    logic [71:0] r;
    r = {a, b, 1'b1, op, 4'b0000};
    for (int i = 71; i >= 4; i--) if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
    return r[3:0];
  endfunction

  function automatic logic [2:0] m_crc3(input logic [31:0] c, input logic [3:0] f);
    logic [39:0] r;
    r = {c, 1'b0, f, 3'b000};
    for (int i = 39; i >= 3; i--) if (r[i]) r[i -: 4] = r[i -: 4] ^ 4'b1011;
    return r[2:0];
  endfunction

  task automatic send_byte(input logic [7:0] d, input logic c);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = d; rx_is_ctl = c;
    @(negedge clk);
    rx_valid = 1'b0; rx_data = 8'h00; rx_is_ctl = 1'b0;
  endtask

  // Returns at the negedge inside the CHECK cycle.
  task automatic send_frame(input vec_t v);
    logic [63:0] w;
    logic [7:0]  c;
    w = {v.a, v.b};
    for (int i = 0; i < v.n; i++) send_byte((i < 8) ? w[63 - 8*i -: 8] : 8'h00, 1'b0);
    c = v.raw ? v.ctl : {1'b0, v.op, m_crc4(v.a, v.b, v.op)};
    send_byte(c, 1'b1);
  endtask

  task automatic get_byte(input logic [7:0] exp_d, input logic exp_c, input string nm);
    int t;
    t = 0;
    while (tx_valid !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    check({nm, "_valid"}, tx_valid, 1);
    check({nm, "_data"}, tx_data, exp_d);
    check({nm, "_is_ctl"}, tx_is_ctl, exp_c);
    @(negedge clk);
  endtask

  task automatic alu_reply(input logic [31:0] r, input logic [3:0] f);
    @(negedge clk);
    alu_done = 1'b1; alu_result = r; alu_flags = f;
    @(negedge clk);
    alu_done = 1'b0; alu_result = '0; alu_flags = '0;
  endtask

  task automatic get_result(input vec_t v);
    for (int i = 0; i < 4; i++) get_byte(v.res[31 - 8*i -: 8], 1'b0, $sformatf("res_c%0d", i));
    get_byte({1'b0, v.flg, m_crc3(v.res, v.flg)}, 1'b1, "res_ctl");
  endtask

  task automatic run_vector(input vec_t v, input string nm);
    int s0;
    s0 = start_cnt;
    send_frame(v);
    check({nm, "_busy_check"}, busy, 1);
    @(negedge clk);
    if (v.err == 8'h00) begin
      check({nm, "_start"}, alu_start, 1);
      check({nm, "_alu_a"}, alu_a, v.a);
      check({nm, "_alu_b"}, alu_b, v.b);
      check({nm, "_alu_op"}, alu_op, v.op);
      @(negedge clk);
      check({nm, "_start_pulse"}, alu_start, 0);
      alu_reply(v.res, v.flg);
      get_result(v);
    end else begin
      check({nm, "_err_latency"}, tx_valid, 1);
      get_byte(v.err, 1'b1, {nm, "_err"});
    end
    check({nm, "_rx_ready"}, rx_ready, 1);
    check({nm, "_busy_end"}, busy, 0);
    check({nm, "_starts"}, start_cnt - s0, (v.err == 8'h00) ? 1 : 0);
  endtask

  vec_t vecs[8];
  vec_t v;
  int   bad;
  logic [7:0] held;

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0; rx_is_ctl = 1'b0;
    alu_done = 1'b0; alu_result = '0; alu_flags = '0; tx_ready = 1'b1;

    vecs[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 8, 3'b000, 1'b0, 8'h00, 32'hFFFFFFFF, 4'b0001, 8'h00};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 8, 3'b100, 1'b0, 8'h00, 32'hFFFFFFFE, 4'b1001, 8'h00};
    vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2, 3'b000, 1'b1, 8'h50, 32'h0, 4'h0, 8'hC9};
    vecs[3] = '{32'h00000005, 32'h00000002, 8, 3'b100, 1'b1, 8'h40, 32'h0, 4'h0, 8'hA5};
    vecs[4] = '{32'h0000000A, 32'h0000000A, 8, 3'b010, 1'b0, 8'h00, 32'h0, 4'h0, 8'h93};
    vecs[5] = '{32'h12345678, 32'h0F0F0F0F, 8, 3'b101, 1'b0, 8'h00, 32'h03254769, 4'b0000, 8'h00};
    vecs[6] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 8, 3'b001, 1'b0, 8'h00, 32'hFFFFFFFF, 4'b0001, 8'h00};
    vecs[7] = '{32'h01020304, 32'h05060708, 9, 3'b000, 1'b0, 8'h00, 32'h0, 4'h0, 8'hC9};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_rx_ready", rx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_alu_start", alu_start, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_is_ctl", tx_is_ctl, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_op", alu_op, 0);

    // Stray alu_done while idle must not start a response.
    alu_reply(32'hDEADBEEF, 4'hF);
    check("stray_done_busy", busy, 0);
    check("stray_done_tx", tx_valid, 0);

    for (int i = 0; i < 8; i++) run_vector(vecs[i], $sformatf("vec%0d", i));

    // Back-pressure on byte 2, plus a DATA byte offered while busy.
    v = vecs[5];
    send_frame(v);
    @(negedge clk);
    check("bp_start", alu_start, 1);
    rx_valid = 1'b1; rx_data = 8'h77; rx_is_ctl = 1'b0;
    @(negedge clk);
    rx_valid = 1'b0; rx_data = 8'h00;
    alu_reply(v.res, v.flg);
    get_byte(v.res[31:24], 1'b0, "bp_b0");
    tx_ready = 1'b0;
    held = tx_data;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx_data !== held || tx_valid !== 1'b1 || tx_is_ctl !== 1'b0) bad++;
    end
    check("bp_hold_unstable_cycles", bad, 0);
    check("bp_held_byte", held, v.res[23:16]);
    tx_ready = 1'b1;
    get_byte(v.res[23:16], 1'b0, "bp_b1");
    get_byte(v.res[15:8], 1'b0, "bp_b2");
    get_byte(v.res[7:0], 1'b0, "bp_b3");
    get_byte({1'b0, v.flg, m_crc3(v.res, v.flg)}, 1'b1, "bp_ctl");
    run_vector(vecs[0], "after_drop");

    // Reset during RUN abandons the operation.
    send_frame(vecs[1]);
    @(negedge clk);
    check("rr_start", alu_start, 1);
    rst = 1'b1;
    #1;
    check("rr_busy", busy, 0);
    check("rr_rx_ready", rx_ready, 1);
    check("rr_alu_a", alu_a, 0);
    check("rr_alu_op", alu_op, 0);
    check("rr_tx_valid", tx_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    alu_reply(32'h12345678, 4'h2);
    check("rr_ignored_done", tx_valid, 0);
    run_vector(vecs[6], "after_rst");

    // Partial frame followed by a long idle gap.
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    repeat (TIMEOUT_CYCLES + 5) @(negedge clk);
    v = vecs[1];
`ifdef ALU_CTRL_TIMEOUT_EN
    v.err = 8'h00;
`else
    v.err = 8'hC9;
`endif
    run_vector(v, "timeout");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
